// File: rtl/atm_pkg.sv
// atm_pkg: shared state codes, menu op encodings and error codes for the ATM session controller
package atm_pkg;
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SCAN    = 4'd1,
    S_PIN     = 4'd2,
    S_MENU    = 4'd3,
    S_WDRAW   = 4'd4,
    S_DEPOSIT = 4'd5,
    S_BALSHOW = 4'd6,
    S_MORE    = 4'd7
  } state_t;
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_BAL   = 2'b01;
  localparam logic [1:0] OP_WDRAW = 2'b10;
  localparam logic [1:0] OP_DEP   = 2'b11;
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PIN     = 3'd1;
  localparam logic [2:0] ERR_FUNDS   = 3'd2;
  localparam logic [2:0] ERR_OP      = 3'd3;
  localparam logic [2:0] ERR_DEP     = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_LOCKED  = 3'd6;
  localparam logic [2:0] ERR_CARD    = 3'd7;
endpackage

// File: rtl/atm_timeout_ctr.sv
// atm_timeout_ctr: idle-cycle counter; expired asserts in the last allowed idle cycle of a wait state
module atm_timeout_ctr #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign expired = en && (cnt == CW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (!en || clr) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session FSM with PIN lockout, held balance with write-back,
// inactivity timeout and explicit error codes.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int PIN_W = 4,
  parameter int AMT_W = 16,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter logic [AMT_W-1:0] MAX_DEP = {AMT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic             card_ok,
  input  logic [PIN_W-1:0] acct_pin,
  input  logic [AMT_W-1:0] acct_bal,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin_in,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic             amt_valid,
  input  logic [AMT_W-1:0] amt,
  input  logic             more_valid,
  input  logic             more,
  output logic [3:0]       state_o,
  output logic [AMT_W-1:0] bal_o,
  output logic             show_bal,
  output logic             dispense,
  output logic [AMT_W-1:0] dispense_amt,
  output logic             bal_wr,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic             card_retain
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  state_t state;
  logic [PIN_W-1:0] pin_q;
  logic [TW-1:0] tries;
  logic [AMT_W:0] sum;
  logic waiting, consumed, expired;
  assign state_o = state;
  assign sum = {1'b0, bal_o} + {1'b0, amt};
  assign waiting = state inside {S_PIN, S_MENU, S_WDRAW, S_DEPOSIT, S_MORE};
  assign consumed = (state == S_PIN && pin_valid) || (state == S_MENU && op_valid) ||
                    ((state == S_WDRAW || state == S_DEPOSIT) && amt_valid) ||
                    (state == S_MORE && more_valid);
  atm_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk(clk),
    .rst(rst),
    .en(waiting),
    .clr(consumed),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      pin_q        <= '0;
      bal_o        <= '0;
      tries        <= '0;
      show_bal     <= 1'b0;
      dispense     <= 1'b0;
      dispense_amt <= '0;
      bal_wr       <= 1'b0;
      err_valid    <= 1'b0;
      err_code     <= ERR_NONE;
      card_retain  <= 1'b0;
    end else begin
      show_bal    <= 1'b0;
      dispense    <= 1'b0;
      bal_wr      <= 1'b0;
      err_valid   <= 1'b0;
      card_retain <= 1'b0;
      // Card removal outranks timeout, which outranks any strobe
      if (state != S_IDLE && !card_in) begin
        err_valid <= 1'b1;
        err_code  <= ERR_CARD;
        state     <= S_IDLE;
      end else if (expired) begin
        err_valid <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (card_in) state <= S_SCAN;
          S_SCAN:
            if (card_ok) begin
              pin_q <= acct_pin;
              bal_o <= acct_bal;
              tries <= '0;
              state <= S_PIN;
            end else state <= S_IDLE;
          S_PIN:
            if (pin_valid) begin
              if (pin_in == pin_q) state <= S_MENU;
              else begin
                tries     <= tries + 1'b1;
                err_valid <= 1'b1;
                if (tries == TW'(MAX_TRIES - 1)) begin
                  err_code    <= ERR_LOCKED;
                  card_retain <= 1'b1;
                  state       <= S_IDLE;
                end else err_code <= ERR_PIN;
              end
            end
          S_MENU:
            if (op_valid) begin
              if (op == OP_BAL) state <= S_BALSHOW;
              else if (op == OP_WDRAW) state <= S_WDRAW;
              else if (op == OP_DEP) state <= S_DEPOSIT;
              else begin
                err_valid <= 1'b1;
                err_code  <= ERR_OP;
              end
            end
          S_WDRAW:
            if (amt_valid) begin
              if (amt != '0 && amt <= bal_o) begin
                bal_o        <= bal_o - amt;
                dispense     <= 1'b1;
                dispense_amt <= amt;
                bal_wr       <= 1'b1;
                state        <= S_MORE;
              end else begin
                err_valid <= 1'b1;
                err_code  <= ERR_FUNDS;
                state     <= S_MENU;
              end
            end
          S_DEPOSIT:
            if (amt_valid) begin
              if (amt <= MAX_DEP && !sum[AMT_W]) begin
                bal_o  <= sum[AMT_W-1:0];
                bal_wr <= 1'b1;
                state  <= S_MORE;
              end else begin
                err_valid <= 1'b1;
                err_code  <= ERR_DEP;
                state     <= S_MENU;
              end
            end
          S_BALSHOW: begin
            show_bal <= 1'b1;
            state    <= S_MORE;
          end
          S_MORE: if (more_valid) state <= more ? S_MENU : S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed session scenarios with hand-computed expectations
module tb_atm_session_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic card_in = 1'b0, card_ok = 1'b0;
  logic [3:0] acct_pin = '0, pin_in = '0;
  logic [7:0] acct_bal = '0, amt = '0;
  logic pin_valid = 1'b0, op_valid = 1'b0, amt_valid = 1'b0, more_valid = 1'b0, more = 1'b0;
  logic [1:0] op = '0;
  logic [3:0] state_o;
  logic [7:0] bal_o, dispense_amt;
  logic show_bal, dispense, bal_wr, err_valid, card_retain;
  logic [2:0] err_code;
  int total = 0, bad = 0;

  atm_session_ctrl #(.PIN_W(4), .AMT_W(8), .MAX_TRIES(3), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_ok(card_ok),
    .acct_pin(acct_pin), .acct_bal(acct_bal), .pin_valid(pin_valid), .pin_in(pin_in),
    .op_valid(op_valid), .op(op), .amt_valid(amt_valid), .amt(amt),
    .more_valid(more_valid), .more(more), .state_o(state_o), .bal_o(bal_o),
    .show_bal(show_bal), .dispense(dispense), .dispense_amt(dispense_amt), .bal_wr(bal_wr),
    .err_valid(err_valid), .err_code(err_code), .card_retain(card_retain)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [3:0] p, input logic [7:0] b);
    acct_pin = p; acct_bal = b; card_ok = 1'b1; card_in = 1'b1;
    tick; tick;
  endtask
  task automatic enter_pin(input logic [3:0] p);
    pin_in = p; pin_valid = 1'b1; tick; pin_valid = 1'b0;
  endtask
  task automatic pick(input logic [1:0] o);
    op = o; op_valid = 1'b1; tick; op_valid = 1'b0;
  endtask
  task automatic give_amt(input logic [7:0] a);
    amt = a; amt_valid = 1'b1; tick; amt_valid = 1'b0;
  endtask
  task automatic answer(input logic m);
    more = m; more_valid = 1'b1; tick; more_valid = 1'b0;
  endtask
  task automatic eject;
    card_in = 1'b0; tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_state", state_o, 0);
    check("rst_bal", bal_o, 0);
    check("rst_err", {err_valid, err_code}, 0);
    check("rst_pulses", {show_bal, dispense, bal_wr, card_retain}, 0);
    rst = 1'b1;
    tick;
    // happy withdraw
    start(4'd5, 8'd100);
    check("scan_pin_state", state_o, 2);
    check("scan_bal", bal_o, 100);
    enter_pin(4'd5);
    check("pin_ok", state_o, 3);
    pick(2'b10);
    check("wdraw_state", state_o, 4);
    give_amt(8'd40);
    check("wd_dispense", dispense, 1);
    check("wd_amt", dispense_amt, 40);
    check("wd_balwr", bal_wr, 1);
    check("wd_bal", bal_o, 60);
    check("wd_more", state_o, 7);
    tick;
    check("wd_pulse_end", {dispense, bal_wr}, 0);
    answer(1'b0);
    check("more0_idle", state_o, 0);
    eject;
    // lockout
    start(4'd5, 8'd100);
    enter_pin(4'd3);
    check("bad1_err", {err_valid, err_code}, {1'b1, 3'd1});
    check("bad1_state", state_o, 2);
    enter_pin(4'd4);
    check("bad2_err", {err_valid, err_code}, {1'b1, 3'd1});
    enter_pin(4'd7);
    check("lock_err", {err_valid, err_code}, {1'b1, 3'd6});
    check("lock_retain", card_retain, 1);
    check("lock_state", state_o, 0);
    eject;
    // balance show
    start(4'd9, 8'd77);
    enter_pin(4'd9);
    pick(2'b01);
    check("balshow_state", state_o, 6);
    tick;
    check("show_pulse", show_bal, 1);
    check("show_more", state_o, 7);
    answer(1'b0);
    eject;
    // overdraft, zero, illegal op, card removal in MENU
    start(4'd5, 8'd100);
    enter_pin(4'd5);
    pick(2'b10);
    give_amt(8'd101);
    check("ovd_err", {err_valid, err_code}, {1'b1, 3'd2});
    check("ovd_state", state_o, 3);
    check("ovd_bal", bal_o, 100);
    pick(2'b10);
    give_amt(8'd0);
    check("zero_err", {err_valid, err_code}, {1'b1, 3'd2});
    check("zero_nodisp", dispense, 0);
    pick(2'b00);
    check("badop_err", {err_valid, err_code}, {1'b1, 3'd3});
    check("badop_state", state_o, 3);
    eject;
    check("menu_eject_err", {err_valid, err_code}, {1'b1, 3'd7});
    check("menu_eject_state", state_o, 0);
    // deposit overflow then fit, then timeout in MENU
    start(4'd5, 8'd250);
    enter_pin(4'd5);
    pick(2'b11);
    check("dep_state", state_o, 5);
    give_amt(8'd10);
    check("depov_err", {err_valid, err_code}, {1'b1, 3'd4});
    check("depov_bal", bal_o, 250);
    check("depov_nowr", bal_wr, 0);
    pick(2'b11);
    give_amt(8'd5);
    check("dep_bal", bal_o, 255);
    check("dep_wr", bal_wr, 1);
    answer(1'b1);
    check("more1_menu", state_o, 3);
    for (int i = 0; i < 7; i++) tick;
    check("pre_timeout", state_o, 3);
    tick;
    check("tmo_err", {err_valid, err_code}, {1'b1, 3'd5});
    check("tmo_state", state_o, 0);
    check("tmo_nowr", bal_wr, 0);
    eject;
    // card removed together with amt_valid in WDRAW
    start(4'd5, 8'd100);
    enter_pin(4'd5);
    pick(2'b10);
    card_in = 1'b0;
    give_amt(8'd10);
    check("rm_err", {err_valid, err_code}, {1'b1, 3'd7});
    check("rm_state", state_o, 0);
    check("rm_nodisp", {dispense, bal_wr}, 0);
    check("rm_bal", bal_o, 100);
    tick;
    // async reset mid-session
    start(4'd5, 8'd100);
    enter_pin(4'd5);
    rst = 1'b0;
    #2;
    check("async_state", state_o, 0);
    check("async_bal", bal_o, 0);
    card_in = 1'b0;
    #1;
    rst = 1'b1;
    tick;
    check("post_rst_idle", state_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Parametrised ATM session controller: the next generation of the team's ATM FSM. It adds handshaked user inputs, configurable PIN/amount widths, a held account balance with write-back, PIN retry lockout, an inactivity timeout and explicit error codes. It sits between the card/keypad front end and the account store. It is the single owner of session state.

## Interface
- PIN_W, 4: PIN width in bits.
- AMT_W, 16: amount and balance width in bits.
- MAX_TRIES, 3: wrong PINs allowed before lockout (≥1).
- TIMEOUT_CYC, 1000: idle cycles in a wait state before abort (≥2).
- MAX_DEP, 2**AMT_W-1: maximum single deposit.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- card_in  in  1  level; card present.
- card_ok  in  1  level; card scan result, sampled in SCAN.
- acct_pin  in  PIN_W  stored PIN; sampled with acct_bal on the SCAN→PIN transition.
- acct_bal  in  AMT_W  stored balance; sampled with acct_pin on the SCAN→PIN transition.
- pin_valid  in  1  strobe; pin_in is valid.
- pin_in  in  PIN_W  entered PIN.
- op_valid  in  1  strobe; op is valid. Encoding: 01 balance, 10 withdraw, 11 deposit, 00 illegal.
- op  in  2  menu option.
- amt_valid  in  1  strobe; amt is valid.
- amt  in  AMT_W  entered amount.
- more_valid  in  1  strobe; more is valid.
- more  in  1  1 = another transaction.
- state_o  out  4  current state code.
- bal_o  out  AMT_W  held balance.
- show_bal  out  1  one-cycle pulse.
- dispense  out  1  one-cycle pulse; dispense_amt is valid.
- dispense_amt  out  AMT_W  withdrawn amount.
- bal_wr  out  1  one-cycle pulse; write bal_o back to account store.
- err_valid  out  1  one-cycle pulse; err_code is valid.
- err_code  out  3  0 none, 1 bad PIN, 2 insufficient funds, 3 bad op, 4 deposit rejected, 5 timeout, 6 locked, 7 card removed.
- card_retain  out  1  one-cycle pulse; swallow card.

## Operation
- States (codes 0–7): IDLE, SCAN, PIN, MENU, WDRAW, DEPOSIT, BALSHOW, MORE.
- IDLE: on card_in=1, go to SCAN.
- SCAN: one cycle only.
  - card_ok=1: latch acct_pin/acct_bal, clear try counter, go to PIN.
  - card_ok=0: go to IDLE.
- PIN: on pin_valid, compare pin_in to the latched PIN.
  - Match: go to MENU.
  - Mismatch: increment tries and pulse err=1.
  - If tries reaches MAX_TRIES: pulse err=6 and card_retain (not err=1), go to IDLE.
  - Otherwise stay in PIN.
- MENU: on op_valid:
  - 01: go to BALSHOW.
  - 10: go to WDRAW.
  - 11: go to DEPOSIT.
  - 00: err=3, stay in MENU.
- WDRAW: on amt_valid:
  - 0 < amt ≤ bal: bal ← bal−amt; pulse dispense with dispense_amt=amt; pulse bal_wr; go to MORE.
  - Otherwise: err=2, go to MENU.
- DEPOSIT: on amt_valid:
  - amt ≤ MAX_DEP and bal+amt has no carry out of AMT_W bits: bal ← bal+amt; pulse bal_wr; go to MORE.
  - Otherwise: err=4, bal unchanged, go to MENU.
- BALSHOW: pulse show_bal, go to MORE (one cycle).
- MORE: on more_valid, go to MENU if more=1, else IDLE.
- Arithmetic: unsigned, AMT_W bits. The overflow check uses an AMT_W+1-bit sum.
- Strobes: ignored in states that do not consume them.

## Timing
- Reset values: state IDLE; all outputs 0; tries 0; latched PIN and balance 0.
- All outputs are registered. Pulses and the updated bal_o appear the cycle after the sampling edge.
- Decision latency: one clock from strobe to new state.
- Timeout counter:
  - Runs in PIN, MENU, WDRAW, DEPOSIT and MORE.
  - Clears on any state change or on a consumed strobe.
  - Reaching TIMEOUT_CYC: err=5, go to IDLE, no bal_wr.
- Priority, highest first: card_in=0 in any non-IDLE state (err=7 → IDLE, no write-back, pending arithmetic discarded); then timeout; then strobes.
- Multiple strobes in one cycle: only the one relevant to the current state is consumed.
- Async reset mid-session: immediate IDLE, no pulses. Any update not yet committed via bal_wr is lost.

## Structure
- atm_pkg:
  - state enum and codes;
  - op encodings;
  - err_code constants.
- Sub-module atm_timeout_ctr, parameter TIMEOUT_CYC, ports clk/rst/en/clr/expired. Counter width is $clog2(TIMEOUT_CYC+1).
- The top level holds the FSM, the try counter, the balance register and the output pulse registers.

## Test plan
- Happy withdraw: acct_bal=100, correct PIN, op=10, amt=40 → dispense with dispense_amt=40, bal_wr, bal_o=60, then MORE; more=0 → IDLE.
- Lockout with MAX_TRIES=3: three wrong PINs → err=1, err=1, then err=6 with card_retain → IDLE.
- Overdraft and zero: bal=100, amt=101 → err=2, MENU, bal_o=100. amt=0 → err=2.
- Deposit overflow, AMT_W=8: bal=250, amt=10 → err=4, bal_o=250. amt=5 → bal_o=255 with bal_wr.
- Timeout with TIMEOUT_CYC=8: sit in MENU 8 cycles with no op_valid → err=5, IDLE, no bal_wr.
- Card removed on the same cycle as amt_valid in WDRAW → err=7, IDLE, no dispense, no bal_wr.
